divider_share_scheduler: RTL

Time-shares one pipelined Xilinx divider (div_gen_0, fixed latency) among several per-colour position accumulators, so the position locator can track multiple dots without one divider pair per tracker. Each requester presents an accumulated x sum, y sum and point count once per frame. The scheduler grants requesters round-robin and issues the x and y divisions back-to-back on the shared divider. A tag pipeline matches returning quotients to requesters, and the scheduler emits one {id, x, y} result per request for the AXI register writer.

---
 rtl/divider_share_scheduler_pkg.sv | 35 +++
 rtl/divider_share_scheduler_if.sv | 45 ++++
 rtl/divider_share_scheduler_rr_arbiter.sv | 47 ++++
 rtl/divider_share_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/divider_share_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_share_scheduler_pkg
// Description : Shared types and constants for the divider share scheduler:
//               FSM state encoding, divider latency default, count-zero
//               sentinels and the tag carried alongside each division.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_share_scheduler_pkg;

    // Matches the div_gen_0 latency setting used by the position locator.
    localparam int c_latency_default = 26;

    // Tag id field is sized for the largest requester count we expect.
    localparam int c_tag_id_w = 8;

    // Reported in place of a quotient when the point count was zero.
    localparam logic [15:0] c_x_sentinel = 16'hffff;
    localparam logic [14:0] c_y_sentinel = 15'h7fff;

    // Scheduler FSM encoding.
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_issue_x = 2'd1;
    localparam logic [1:0] c_st_issue_y = 2'd2;

    // Travels with each division so the returning quotient can be matched.
    typedef struct packed {
        logic                  valid;
        logic [c_tag_id_w-1:0] id;
        logic                  is_y;
        logic                  zero;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/divider_share_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : divider_share_scheduler_if
// Description : Bundles the requester handshake, the shared divider ports and
//               the result stream of the divider share scheduler. The slave
//               modport is the scheduler view; master is the environment view
//               (requesters, divider and result consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface divider_share_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) ();

    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_acc_x;
    logic [32*N_REQ-1:0] req_acc_y;
    logic [24*N_REQ-1:0] req_count;
    logic [N_REQ-1:0]    req_ack;

    logic [31:0]         div_dividend;
    logic [23:0]         div_divisor;
    logic                div_valid;
    logic [39:0]         div_dout;

    logic                result_valid;
    logic [ID_W-1:0]     result_id;
    logic [15:0]         result_x;
    logic [14:0]         result_y;
    logic                busy;

    modport master (
        output req_valid, req_acc_x, req_acc_y, req_count, div_dout,
        input  req_ack, div_dividend, div_divisor, div_valid,
        input  result_valid, result_id, result_x, result_y, busy
    );

    modport slave (
        input  req_valid, req_acc_x, req_acc_y, req_count, div_dout,
        output req_ack, div_dividend, div_divisor, div_valid,
        output result_valid, result_id, result_x, result_y, busy
    );

endinterface
`default_nettype wire

// File: rtl/divider_share_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : divider_share_scheduler_rr_arbiter
// Description : Pointer-based round-robin arbiter. The first requester at or
//               above the pointer wins, wrapping to index 0. Produces a
//               one-hot grant and the binary index of the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_share_scheduler_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]  i_pointer,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [ID_W-1:0]  o_grant_idx,
    output logic                  o_any
);

    localparam logic [ID_W:0] c_n_req = (ID_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic [ID_W-1:0]    w_offset;
    logic [ID_W:0]      w_sum;

    // Rotate so the pointer position lands on bit 0; wrap comes for free.
    assign w_req_dbl = {i_req, i_req};
    assign w_req_rot = N_REQ'(w_req_dbl >> i_pointer);

    // Lowest set bit of the rotated vector is the distance to the winner.
    always_comb begin
        w_offset = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_offset = ID_W'(k);
            end
        end
    end

    assign w_sum       = {1'b0, i_pointer} + {1'b0, w_offset};
    assign o_grant_idx = (w_sum >= c_n_req) ? ID_W'(w_sum - c_n_req) : w_sum[ID_W-1:0];
    assign o_any       = |i_req;
    assign o_grant     = o_any ? (N_REQ'(1) << o_grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/divider_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : divider_share_scheduler
// Description : Time-shares one pipelined divider among N_REQ position
//               accumulators. Grants round-robin, issues x then y division
//               back-to-back, and matches returning quotients through a tag
//               pipeline to emit one {id, x, y} result per request.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_share_scheduler
    import divider_share_scheduler_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int LATENCY  = c_latency_default,
    parameter int QUOT_LSB = 8
) (
    input wire logic                 clk,
    input wire logic                 reset,
    divider_share_scheduler_if.slave bus
);

    localparam logic [ID_W-1:0] c_last_idx = ID_W'(N_REQ - 1);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [31:0]      r_x;
    logic [31:0]      r_y;
    logic [23:0]      r_cnt;
    logic [ID_W-1:0]  r_id;
    logic [N_REQ-1:0] r_ack;
    logic             r_div_valid;
    logic [31:0]      r_dividend;
    logic [23:0]      r_divisor;
    tag_t             r_issue_tag;
    tag_t             r_tag [LATENCY];
    logic [15:0]      r_hold_x;
    logic             r_result_valid;
    logic [ID_W-1:0]  r_result_id;
    logic [15:0]      r_result_x;
    logic [14:0]      r_result_y;

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_any;
    logic [ID_W-1:0]  w_next_ptr;
    logic [31:0]      w_sel_x;
    logic [31:0]      w_sel_y;
    logic [23:0]      w_sel_cnt;
    tag_t             w_exit_tag;
    logic             w_tags_busy;
    logic             w_unused;

    divider_share_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arbiter (
        .i_req       (bus.req_valid),
        .i_pointer   (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_next_ptr = (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + ID_W'(1);

    // Select the winning requester's operands from the packed buses.
    always_comb begin
        w_sel_x   = '0;
        w_sel_y   = '0;
        w_sel_cnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant_idx == ID_W'(k)) begin
                w_sel_x   = bus.req_acc_x[32*k +: 32];
                w_sel_y   = bus.req_acc_y[32*k +: 32];
                w_sel_cnt = bus.req_count[24*k +: 24];
            end
        end
    end

    // Grant / issue FSM; divider inputs and the issue tag are registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_ptr       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_id        <= '0;
            r_ack       <= '0;
            r_div_valid <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_issue_tag <= '0;
        end else begin
            r_ack       <= '0;
            r_div_valid <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_issue_tag <= '0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_ack   <= w_grant;
                        r_x     <= w_sel_x;
                        r_y     <= w_sel_y;
                        r_cnt   <= w_sel_cnt;
                        r_id    <= w_grant_idx;
                        r_ptr   <= w_next_ptr;
                        r_state <= c_st_issue_x;
                    end
                end
                c_st_issue_x: begin
                    r_div_valid       <= 1'b1;
                    r_dividend        <= r_x;
                    r_divisor         <= r_cnt;
                    r_issue_tag.valid <= 1'b1;
                    r_issue_tag.id    <= c_tag_id_w'(r_id);
                    r_issue_tag.is_y  <= 1'b0;
                    r_issue_tag.zero  <= (r_cnt == '0);
                    r_state           <= c_st_issue_y;
                end
                c_st_issue_y: begin
                    r_div_valid       <= 1'b1;
                    r_dividend        <= r_y;
                    r_divisor         <= r_cnt;
                    r_issue_tag.valid <= 1'b1;
                    r_issue_tag.id    <= c_tag_id_w'(r_id);
                    r_issue_tag.is_y  <= 1'b1;
                    r_issue_tag.zero  <= (r_cnt == '0);
                    r_state           <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Tag delay line: the tag exits in the same cycle its quotient appears on div_dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= r_issue_tag;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_exit_tag = r_tag[LATENCY-1];

    // Any division still in flight keeps the block busy.
    always_comb begin
        w_tags_busy = r_issue_tag.valid;
        for (int k = 0; k < LATENCY; k++) begin
            w_tags_busy = w_tags_busy | r_tag[k].valid;
        end
    end

    // Hold the x quotient, then emit the full result when the y quotient returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_x       <= '0;
            r_result_valid <= 1'b0;
            r_result_id    <= '0;
            r_result_x     <= '0;
            r_result_y     <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_exit_tag.valid && !w_exit_tag.is_y) begin
                r_hold_x <= bus.div_dout[QUOT_LSB +: 16];
            end
            if (w_exit_tag.valid && w_exit_tag.is_y) begin
                r_result_valid <= 1'b1;
                r_result_id    <= w_exit_tag.id[ID_W-1:0];
                r_result_x     <= w_exit_tag.zero ? c_x_sentinel : r_hold_x;
                r_result_y     <= w_exit_tag.zero ? c_y_sentinel : bus.div_dout[QUOT_LSB +: 15];
            end
        end
    end

    // Upper tag id bits and the fractional / high quotient bits are not needed.
    assign w_unused = ^{w_exit_tag.id, bus.div_dout};

    assign bus.req_ack      = r_ack;
    assign bus.div_valid    = r_div_valid;
    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
    assign bus.result_valid = r_result_valid;
    assign bus.result_id    = r_result_id;
    assign bus.result_x     = r_result_x;
    assign bus.result_y     = r_result_y;
    assign bus.busy         = (r_state != c_st_idle) | w_tags_busy;

endmodule
`default_nettype wire
